// File: rtl/gpr_mp_pkg.sv
// gpr_mp_pkg: shared CPU defaults for the multi-ported register file.
package gpr_mp_pkg;
  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;
  localparam int NRD_DEF = 2;
  localparam int ZERO_REG = 0;
endpackage

// File: rtl/gpr_scoreboard.sv
// gpr_scoreboard: per-register busy bits; an issue beats a retiring write to the same register.
module gpr_scoreboard import gpr_mp_pkg::*; #(
  parameter int AW = AW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  input  logic            we0,
  input  logic [AW-1:0]   wa0,
  input  logic            we1,
  input  logic [AW-1:0]   wa1,
  output logic [2**AW-1:0] busy_vec
);
  logic [2**AW-1:0] busy_q, busy_d;
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < 2**AW; i++) begin
      if ((we0 && wa0 == AW'(i)) || (we1 && wa1 == AW'(i))) busy_d[i] = 1'b0;
      if (iss_en && iss_rd == AW'(i)) busy_d[i] = 1'b1;
    end
    busy_d[ZERO_REG] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else busy_q <= busy_d;
  end
  assign busy_vec = busy_q;
endmodule

// File: rtl/gpr_mp.sv
// gpr_mp: register file with two write ports, NRD combinational read ports and optional forwarding.
module gpr_mp import gpr_mp_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int NRD = NRD_DEF,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*DW-1:0] rdata,
  output logic [NRD-1:0]    rbusy,
  input  logic              we0,
  input  logic [AW-1:0]     wa0,
  input  logic [DW-1:0]     wd0,
  input  logic              we1,
  input  logic [AW-1:0]     wa1,
  input  logic [DW-1:0]     wd1,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_rd,
  output logic [2**AW-1:0]  busy_vec
);
  logic [DW-1:0] mem_q [2**AW];
  logic wr0, wr1;
  assign wr0 = we0 && wa0 != AW'(ZERO_REG);
  assign wr1 = we1 && wa1 != AW'(ZERO_REG);
  // Port 1 is written last so it wins a same-address conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**AW; i++) mem_q[i] <= '0;
    end else begin
      if (wr0) mem_q[wa0] <= wd0;
      if (wr1) mem_q[wa1] <= wd1;
    end
  end
  gpr_scoreboard #(.AW(AW)) u_sb (
    .clk(clk), .rst(rst), .iss_en(iss_en), .iss_rd(iss_rd),
    .we0(we0), .wa0(wa0), .we1(we1), .wa1(wa1), .busy_vec(busy_vec)
  );
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] a;
    assign a = ra[p*AW +: AW];
    assign rdata[p*DW +: DW] = (BYPASS != 0 && wr1 && wa1 == a) ? wd1 :
                               (BYPASS != 0 && wr0 && wa0 == a) ? wd0 :
                               (a == AW'(ZERO_REG)) ? '0 : mem_q[a];
    assign rbusy[p] = busy_vec[a];
  end
endmodule
